// File: rtl/alu_seq16_pkg.sv
// Shared op-code and FSM state definitions for the EX-stage ALU and its control decoder.
package alu_seq16_pkg;
  localparam int ALU_WIDTH   = 16;
  localparam int ALU_SHAMT_W = 4;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_SLL = 3'b100,
    OP_ROR = 3'b101,
    OP_SUB = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_e;
endpackage

// File: rtl/mul_shift_add16.sv
// Iterative shift-add multiplier datapath: one partial product per step, unsigned 2*WIDTH result.
module mul_shift_add16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [CNT_W-1:0]   count,
  output logic [2*WIDTH-1:0] product
);
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  // Product including the current step, so the final step can be captured on the same edge.
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count    <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      count    <= '0;
    end else if (step) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count    <= count + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq16.sv
// Sequential 16-bit EX-stage ALU: single-cycle logic/arith/shift ops plus an iterative MUL.
module alu_seq16
  import alu_seq16_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       operacioni,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);
  localparam int CNT_W = $clog2(WIDTH);

  state_e             state;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   b_eff;
  logic [2*WIDTH-1:0] rot;
  logic               accept, mul_load, mul_step;
  logic [CNT_W-1:0]   mul_count;
  logic [2*WIDTH-1:0] mul_product;

  // A request is taken whenever the block is not busy, including the Done cycle.
  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign mul_load = accept && (op_e'(operacioni) == OP_MUL);
  assign mul_step = (state == S_MUL);

  mul_shift_add16 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (mul_load),
    .step    (mul_step),
    .a       (a),
    .b       (b),
    .count   (mul_count),
    .product (mul_product)
  );

  // SUB shares the adder as A + ~B + 1, so Carry reads as "no borrow".
  assign b_eff = (op_q == OP_SUB) ? ~b_q : b_q;
  assign sum   = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_q == OP_SUB)};
  assign rot   = {a_q, a_q} >> b_q[SHAMT_W-1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLL: alu_res = a_q << b_q[SHAMT_W-1:0];
      OP_ROR: alu_res = rot[WIDTH-1:0];
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: alu_res = '0;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_AND;
      a_q       <= '0;
      b_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q  <= op_e'(operacioni);
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= mul_load ? S_MUL : S_EXEC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_EXEC: begin
          result    <= alu_res;
          result_hi <= '0;
          zero      <= (alu_res == '0);
          carry     <= alu_c;
          overflow  <= alu_v;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_MUL: begin
          if (mul_count == CNT_W'(WIDTH - 1)) begin
            result    <= mul_product[WIDTH-1:0];
            result_hi <= mul_product[2*WIDTH-1:WIDTH];
            zero      <= (mul_product[WIDTH-1:0] == '0);
            carry     <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
